// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM state encoding,
// default bus widths, slave count and the APB slave base addresses
// (the same map ahb_slave decodes against).
// Optional build macro: APB_PREADY_EN (honour APB pready wait states).
package apb_bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int NSLV_DEF   = 3;

    // Slave windows are 64 MiB each, starting at these bases.
    localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE = 32'h8800_0000;

    // Six legal encodings; 6 and 7 are unreachable and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_SETUP  = 3'd1,
        ST_RD_ACCESS = 3'd2,
        ST_WR_WAIT   = 3'd3,
        ST_WR_SETUP  = 3'd4,
        ST_WR_ACCESS = 3'd5
    } state_t;

    // True for the two APB ACCESS states.
    function automatic logic is_access(input state_t s);
        return (s == ST_RD_ACCESS) || (s == ST_WR_ACCESS);
    endfunction

endpackage

// File: rtl/apb_controller_if.sv
// Signal bundle between the AHB-side decode (ahb_slave), the bridge
// sequencer and the APB slaves. The slave modport is the sequencer's view
// (it is the AHB slave of the bridge); master is the environment driving it.
// Optional build macro: APB_PREADY_EN (pready only matters when defined).
interface apb_controller_if
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSLV   = NSLV_DEF
);
    // AHB side (from ahb_slave / AHB master)
    logic              valid;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [NSLV-1:0]   temp_selx;
    logic              hreadyout;
    logic [DATA_W-1:0] hrdata;

    // APB side
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic [NSLV-1:0]   pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

    modport slave (
        input  valid, hwrite, haddr, hwdata, temp_selx, prdata, pready,
        output pselx, penable, pwrite, paddr, pwdata, hreadyout, hrdata
    );

    modport master (
        output valid, hwrite, haddr, hwdata, temp_selx, prdata, pready,
        input  pselx, penable, pwrite, paddr, pwdata, hreadyout, hrdata
    );

endinterface

// File: rtl/apb_controller.sv
// Sequencing FSM of the AHB-to-APB bridge. Each accepted AHB transfer is
// run as one APB SETUP/ACCESS pair; hreadyout stalls the AHB data phase
// until the ACCESS cycle completes. Writes spend one extra cycle (WR_WAIT)
// because hwdata only arrives in the AHB data phase.
// Optional build macro: APB_PREADY_EN -- when defined, ACCESS waits for
// pready=1; when undefined, pready is ignored and ACCESS lasts one cycle.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSLV   = NSLV_DEF
) (
    input  logic           hclk,
    input  logic           hresetn,
    apb_controller_if.slave bus
);

    state_t            state_q, state_d;
    logic [NSLV-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    // Write address/select captured in the address phase, replayed in WR_SETUP.
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic hreadyout_c;
    logic accept;
    logic pready_ok;

`ifdef APB_PREADY_EN
    assign pready_ok = bus.pready;
`else
    assign pready_ok = 1'b1;
`endif

    // State and APB output registers, asynchronously cleared.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            pselx_q   <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
        end
    end

    // Next-state, next APB outputs and hreadyout decode.
    always_comb begin
        state_d     = state_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        hreadyout_c = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hreadyout_c = 1'b1;
                accept      = 1'b1;
            end
            ST_RD_SETUP: begin
                state_d   = ST_RD_ACCESS;
                penable_d = 1'b1;
            end
            ST_WR_WAIT: begin
                // hwdata is valid now (AHB data phase of the write).
                state_d  = ST_WR_SETUP;
                pselx_d  = sel_q;
                paddr_d  = addr_q;
                pwdata_d = bus.hwdata;
                pwrite_d = 1'b1;
            end
            ST_WR_SETUP: begin
                state_d   = ST_WR_ACCESS;
                penable_d = 1'b1;
            end
            ST_RD_ACCESS, ST_WR_ACCESS: begin
                // Not yet complete: hold every APB output, keep the master stalled.
                if (penable_q && pready_ok) begin
                    hreadyout_c = 1'b1;
                    accept      = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pselx_d   = '0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end
        endcase

        // Accept point: IDLE or a completing ACCESS, so transfers chain with no gap.
        if (accept) begin
            if (bus.valid && !bus.hwrite) begin
                state_d   = ST_RD_SETUP;
                pselx_d   = bus.temp_selx;
                paddr_d   = bus.haddr;
                pwrite_d  = 1'b0;
                penable_d = 1'b0;
            end else if (bus.valid && bus.hwrite) begin
                state_d   = ST_WR_WAIT;
                sel_d     = bus.temp_selx;
                addr_d    = bus.haddr;
                pselx_d   = '0;
                penable_d = 1'b0;
            end else begin
                state_d   = ST_IDLE;
                pselx_d   = '0;
                penable_d = 1'b0;
            end
        end
    end

    assign bus.pselx     = pselx_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.hreadyout = hreadyout_c;
    assign bus.hrdata    = bus.prdata;

endmodule

// File: tb/tb_apb_controller.sv
// Testbench for apb_controller. Expected APB transfers are queued when the
// AHB side issues them and checked when the DUT completes an ACCESS cycle;
// each scenario task also checks cycle-by-cycle timing inline.
// Build with +define+APB_PREADY_EN to exercise pready wait states.
module tb_apb_controller;

    logic hclk;
    logic hresetn;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t mon_exp;

    apb_controller_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();

    apb_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // Scoreboard: every completing ACCESS must match the oldest queued transfer.
    always @(negedge hclk) begin
        if (hresetn && bus.penable && bus.hreadyout && bus.pselx != 3'b000) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got access addr=%h sel=%b, want none", bus.paddr, bus.pselx);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.pselx !== mon_exp.sel || bus.paddr !== mon_exp.addr ||
                    bus.pwrite !== mon_exp.wr ||
                    (mon_exp.wr ? (bus.pwdata !== mon_exp.data) : (bus.hrdata !== mon_exp.data))) begin
                    n_fail++;
                    $display("FAIL sb_access: got wr=%b sel=%b addr=%h wdata=%h rdata=%h, want wr=%b sel=%b addr=%h data=%h",
                             bus.pwrite, bus.pselx, bus.paddr, bus.pwdata, bus.hrdata,
                             mon_exp.wr, mon_exp.sel, mon_exp.addr, mon_exp.data);
                end else begin
                    $display("txn %s sel=%b addr=%h data=%h ok", mon_exp.wr ? "WR" : "RD",
                             mon_exp.sel, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [2:0] s);
        bus.valid     = v;
        bus.hwrite    = w;
        bus.haddr     = a;
        bus.temp_selx = s;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        n_checks++;
        if (bus.pselx !== 3'b000 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0 ||
            bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.hreadyout !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hready=%b, want 000 0 0 0 0 1",
                     bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.hreadyout);
        end
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_read();
        tick();
        drive(1'b1, 1'b0, 32'h8000_0010, 3'b001);
        bus.prdata = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 3'b001, 32'h8000_0010, 32'hDEAD_BEEF});
        @(negedge hclk);
        n_checks++;
        if (bus.hreadyout !== 1'b1) begin n_fail++; $display("FAIL rd_hready_t0: got %b want 1", bus.hreadyout); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b001 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b0 || bus.paddr !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL rd_setup_t1: got psel=%b pen=%b hready=%b paddr=%h, want 001 0 0 80000010",
                     bus.pselx, bus.penable, bus.hreadyout, bus.paddr);
        end
        tick();
        @(negedge hclk);
        n_checks++;
        if (bus.penable !== 1'b1 || bus.hreadyout !== 1'b1 || bus.hrdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rd_access_t2: got pen=%b hready=%b hrdata=%h, want 1 1 deadbeef",
                     bus.penable, bus.hreadyout, bus.hrdata);
        end
        tick();
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b000 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_idle_t3: got psel=%b pen=%b hready=%b, want 000 0 1", bus.pselx, bus.penable, bus.hreadyout);
        end
    endtask

    task automatic test_write();
        tick();
        drive(1'b1, 1'b1, 32'h8400_0004, 3'b010);
        bus.hwdata = 32'hFFFF_FFFF;
        sb.push_back('{1'b1, 3'b010, 32'h8400_0004, 32'hA5A5_0001});
        @(negedge hclk);
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        bus.hwdata = 32'hA5A5_0001;
        @(negedge hclk);
        n_checks++;
        if (bus.hreadyout !== 1'b0 || bus.pselx !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_wait_t1: got hready=%b psel=%b, want 0 000", bus.hreadyout, bus.pselx);
        end
        tick();
        bus.hwdata = 32'h0000_0000;
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b010 || bus.pwrite !== 1'b1 || bus.paddr !== 32'h8400_0004 ||
            bus.pwdata !== 32'hA5A5_0001 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_setup_t2: got psel=%b pwr=%b paddr=%h pwdata=%h pen=%b hready=%b, want 010 1 84000004 a5a50001 0 0",
                     bus.pselx, bus.pwrite, bus.paddr, bus.pwdata, bus.penable, bus.hreadyout);
        end
        tick();
        @(negedge hclk);
        n_checks++;
        if (bus.penable !== 1'b1 || bus.hreadyout !== 1'b1 || bus.pwdata !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL wr_access_t3: got pen=%b hready=%b pwdata=%h, want 1 1 a5a50001",
                     bus.penable, bus.hreadyout, bus.pwdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        tick();
        drive(1'b1, 1'b0, 32'h8800_0000, 3'b100);
        bus.prdata = 32'h1357_9BDF;
        sb.push_back('{1'b0, 3'b100, 32'h8800_0000, 32'h1357_9BDF});
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b100) begin n_fail++; $display("FAIL b2b_rd_sel: got %b want 100", bus.pselx); end
        tick();
        drive(1'b1, 1'b1, 32'h8000_0008, 3'b001);
        sb.push_back('{1'b1, 3'b001, 32'h8000_0008, 32'h1234_5678});
        @(negedge hclk);
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        bus.hwdata = 32'h1234_5678;
        @(negedge hclk);
        // WR_WAIT, not IDLE: the master must still be stalled.
        n_checks++;
        if (bus.hreadyout !== 1'b0 || bus.pselx !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_no_idle: got hready=%b psel=%b, want 0 000", bus.hreadyout, bus.pselx);
        end
        tick();
        bus.hwdata = 32'h0;
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b001 || bus.pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_wr_sel: got psel=%b pwr=%b, want 001 1", bus.pselx, bus.pwrite);
        end
        repeat (2) tick();
    endtask

    task automatic test_held_valid();
        tick();
        drive(1'b1, 1'b1, 32'h8800_0004, 3'b100);
        sb.push_back('{1'b1, 3'b100, 32'h8800_0004, 32'h5A5A_5A5A});
        sb.push_back('{1'b0, 3'b001, 32'h8000_0010, 32'h0F0F_0F0F});
        tick();
        // Next address phase presented during the stall; must wait for the accept point.
        drive(1'b1, 1'b0, 32'h8000_0010, 3'b001);
        bus.hwdata = 32'h5A5A_5A5A;
        bus.prdata = 32'h0F0F_0F0F;
        tick();
        bus.hwdata = 32'h0;
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b100 || bus.paddr !== 32'h8800_0004 || bus.pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL held_wr_setup: got psel=%b paddr=%h pwr=%b, want 100 88000004 1", bus.pselx, bus.paddr, bus.pwrite);
        end
        tick();
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b001 || bus.paddr !== 32'h8000_0010 || bus.pwrite !== 1'b0 || bus.hreadyout !== 1'b0) begin
            n_fail++;
            $display("FAIL held_rd_setup: got psel=%b paddr=%h pwr=%b hready=%b, want 001 80000010 0 0",
                     bus.pselx, bus.paddr, bus.pwrite, bus.hreadyout);
        end
        repeat (2) tick();
    endtask

    task automatic test_out_of_range();
        drive(1'b0, 1'b0, 32'h9000_0000, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge hclk);
            n_checks++;
            if (bus.pselx !== 3'b000 || bus.hreadyout !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_cycle%0d: got psel=%b hready=%b, want 000 1", i, bus.pselx, bus.hreadyout);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        drive(1'b1, 1'b1, 32'h8400_0004, 3'b010);
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        bus.hwdata = 32'h7777_0000;
        tick();
        tick();
        // Now in WR_ACCESS; the write is cut off by reset and never completes.
        n_checks++;
        if (bus.penable !== 1'b1) begin n_fail++; $display("FAIL arst_in_access: got pen=%b want 1", bus.penable); end
        #1 hresetn = 1'b0;
        #1;
        n_checks++;
        if (bus.pselx !== 3'b000 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_immediate: got psel=%b pen=%b hready=%b, want 000 0 1", bus.pselx, bus.penable, bus.hreadyout);
        end
        sb.delete();
        tick();
        hresetn = 1'b1;
        tick();
        drive(1'b1, 1'b0, 32'h8800_0000, 3'b100);
        bus.prdata = 32'hCAFE_0001;
        sb.push_back('{1'b0, 3'b100, 32'h8800_0000, 32'hCAFE_0001});
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge hclk);
        n_checks++;
        if (bus.pselx !== 3'b100 || bus.hreadyout !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_after_setup: got psel=%b hready=%b, want 100 0", bus.pselx, bus.hreadyout);
        end
        tick();
        @(negedge hclk);
        n_checks++;
        if (bus.penable !== 1'b1 || bus.hrdata !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL arst_after_access: got pen=%b hrdata=%h, want 1 cafe0001", bus.penable, bus.hrdata);
        end
        tick();
    endtask

`ifdef APB_PREADY_EN
    task automatic test_pready();
        int low_cycles;
        low_cycles = 0;
        tick();
        drive(1'b1, 1'b0, 32'h8000_0010, 3'b001);
        bus.prdata = 32'h0BAD_F00D;
        sb.push_back('{1'b0, 3'b001, 32'h8000_0010, 32'h0BAD_F00D});
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge hclk);
        if (bus.hreadyout === 1'b0) low_cycles++;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.pready = 1'b0;
            @(negedge hclk);
            if (bus.hreadyout === 1'b0) low_cycles++;
            n_checks++;
            if (bus.penable !== 1'b1 || bus.paddr !== 32'h8000_0010 || bus.pselx !== 3'b001 || bus.hreadyout !== 1'b0) begin
                n_fail++;
                $display("FAIL pready_hold%0d: got pen=%b paddr=%h psel=%b hready=%b, want 1 80000010 001 0",
                         i, bus.penable, bus.paddr, bus.pselx, bus.hreadyout);
            end
        end
        tick();
        bus.pready = 1'b1;
        @(negedge hclk);
        n_checks++;
        if (bus.hreadyout !== 1'b1 || low_cycles != 4) begin
            n_fail++;
            $display("FAIL pready_complete: got hready=%b low_cycles=%0d, want 1 4", bus.hreadyout, low_cycles);
        end
        tick();
    endtask
`else
    task automatic test_pready();
        tick();
        drive(1'b1, 1'b0, 32'h8000_0010, 3'b001);
        bus.prdata = 32'h0BAD_F00D;
        bus.pready = 1'b0;
        sb.push_back('{1'b0, 3'b001, 32'h8000_0010, 32'h0BAD_F00D});
        tick();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        tick();
        @(negedge hclk);
        n_checks++;
        if (bus.penable !== 1'b1 || bus.hreadyout !== 1'b1) begin
            n_fail++;
            $display("FAIL pready_ignored: got pen=%b hready=%b, want 1 1", bus.penable, bus.hreadyout);
        end
        tick();
        bus.pready = 1'b1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hresetn  = 1'b0;
        bus.valid     = 1'b0;
        bus.hwrite    = 1'b0;
        bus.haddr     = 32'h0;
        bus.hwdata    = 32'h0;
        bus.temp_selx = 3'b000;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b1;

        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_held_valid();
        test_out_of_range();
        test_async_reset();
        test_pready();
        repeat (2) tick();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending transfers, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
